ps2_word_packer: RTL and testbench
==================================

# ps2_word_packer

Upstream stage of the RSA engine's `rsa_data_i` input. It assembles bytes from the PS/2 keyboard decoder into 32-bit words and buffers them in a small FIFO. Words are presented to the RSA core over a valid/ready handshake. The PS/2 source cannot be back-pressured, so overruns are flagged rather than stalled.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of two, minimum 2.
- CNT_W, 16, width of the per-message word counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  when 1: word_valid_o forced 0 and no FIFO pops; byte capture continues.
- ps2_data_i  input  8  decoded key byte.
- ps2_valid_i  input  1  ps2_data_i valid this cycle; one-cycle pulse per byte.
- ps2_done  input  1  end-of-message pulse; flushes any partial word.
- ps2_reset  input  1  synchronous clear of packer, FIFO, counter and overflow flag.
- word_data_o  output  32  FIFO head word; drives rsa_data_i.
- word_valid_o  output  1  head word valid; drives rsa_valid_i.
- word_ready_i  input  1  consumer accepts; from rsa_ready_o.
- word_count_o  output  CNT_W  words pushed since last reset/ps2_reset; saturates at all-ones.
- overflow_o  output  1  sticky; a word was dropped because the FIFO was full.

## Operation
- Packing register plus 2-bit byte index `idx` (0..3). Big-endian: byte 0 goes to [31:24], byte 3 to [7:0].
- On ps2_valid_i: write byte at lane `idx`, then `idx` increments.
  - At idx==3 the completed word is pushed and `idx` returns to 0.
- On ps2_done with partial word (`idx` 1..3): push the word with unfilled lanes zero, then `idx`=0.
  - With `idx`==0, ps2_done does nothing; no empty word is pushed.
- ps2_valid_i and ps2_done in the same cycle: the byte is packed first, then the (possibly now complete) word is flushed.
  - At most one push per cycle.
- Push while FIFO full:
  - the word is discarded;
  - overflow_o sets;
  - `idx` still resets to 0;
  - word_count_o does not increment.
- Push and pop in the same cycle when full: the pop frees the slot and the push succeeds (no overflow).
- Pop occurs when word_valid_o && word_ready_i.
- word_count_o increments on every successful push.
- Priority: rst > ps2_reset > normal operation. ps2_reset discards all FIFO contents and the partial word.

## Timing
- Reset values (rst low, asynchronous):
  - word_valid_o=0, word_data_o=0, word_count_o=0, overflow_o=0;
  - idx=0, FIFO empty.
- Same values one cycle after ps2_reset is sampled high.
- Latency: the byte completing a word is sampled at edge N; word_valid_o=1 during the following cycle when the FIFO was empty (registered push).
  - Flush on ps2_done has the same latency.
- word_data_o comes directly from the FIFO head register/RAM read.
  - It is stable while word_valid_o=1 and not popped.
- Valid/ready: word_valid_o never depends combinationally on word_ready_i. Once asserted, it stays high until a pop or stall.
  - stall drops word_valid_o in the same cycle (combinational gate) without changing FIFO state.
- Throughput: one pop per cycle; at most one push per 4 bytes plus one per ps2_done.
- Pointers are log2(DEPTH)+1 bits; full and empty are detected by MSB compare, wrapping cleanly.

## Test plan
- Reset, then bytes 0x12,0x34,0x56,0x78 with word_ready_i=1 -> one cycle after the 4th byte, word_valid_o=1 and word_data_o=0x12345678; popped; word_count_o=1.
- Bytes 0xAB,0xCD then ps2_done -> word 0xABCD0000 pushed; a second ps2_done with idx=0 pushes nothing; word_count_o unchanged.
- 0x01,0x02,0x03 then 0x04 together with ps2_done -> exactly one word 0x01020304; no extra zero word.
- word_ready_i=0 while DEPTH+1 words are fed -> FIFO holds the first DEPTH words in order; overflow_o=1; word_count_o=DEPTH. Then ready=1 drains them in order, back-to-back.
- stall=1 with a full FIFO and ready=1 -> word_valid_o=0 and no pops. Release stall -> drain resumes with data unchanged.
- Two bytes packed and 2 words queued, then ps2_reset pulse -> next cycle word_valid_o=0, count=0, overflow=0. Next bytes 0xDE,0xAD,0xBE,0xEF give 0xDEADBEEF. Asserting rst mid-word clears the same state asynchronously.

Source files
------------

// File: rtl/ps2_word_packer.sv
// ps2_word_packer: packs PS/2 key bytes big-endian into 32-bit words and
// queues them in a small FIFO for the RSA core's valid/ready input.
// The PS/2 side cannot be stalled, so a word arriving at a full FIFO is
// dropped and recorded in a sticky overflow flag.
module ps2_word_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [7:0]       ps2_data_i,
  input  logic             ps2_valid_i,
  input  logic             ps2_done,
  input  logic             ps2_reset,
  output logic [31:0]      word_data_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [CNT_W-1:0] word_count_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Packing state
  logic [31:0] pack_q;
  logic [31:0] pack_next;
  logic [1:0]  idx_q;
  logic        push_req;

  // FIFO state
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;

  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  // Merge the incoming byte into its big-endian lane (lane 0 is [31:24]).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pack_next = pack_q;
    if (ps2_valid_i) begin
      case (idx_q)
        2'd0:    pack_next[31:24] = ps2_data_i;
        2'd1:    pack_next[23:16] = ps2_data_i;
        2'd2:    pack_next[15:8]  = ps2_data_i;
        default: pack_next[7:0]   = ps2_data_i;
      endcase
    end
  end

  // A word leaves the packer when its last lane fills, or on ps2_done when
  // at least one lane (including a byte arriving this cycle) is filled.
  // Both conditions collapse into a single push, so at most one per cycle.
  assign push_req = (ps2_valid_i && (idx_q == 2'd3)) ||
                    (ps2_done && (ps2_valid_i || (idx_q != 2'd0)));

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // stall only masks the handshake; it never touches FIFO state.
  assign word_valid_o = !fifo_empty && !stall;
  assign pop          = word_valid_o && word_ready_i;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // still succeeds when the consumer is draining.
  assign push_ok      = push_req && (!fifo_full || pop);

  assign word_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign word_count_o = count_q;
  assign overflow_o   = overflow_q;

  // Packing register and lane index; both clear whenever a word is pushed
  // (or dropped) so the next word starts with unfilled lanes at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is assigned with <= so every register samples
      // the pre-edge values of the others, independent of statement order.
      pack_q <= '0;
      idx_q  <= 2'd0;
    end else if (ps2_reset) begin
      pack_q <= '0;
      idx_q  <= 2'd0;
    end else if (push_req) begin
      pack_q <= '0;
      idx_q  <= 2'd0;
    end else if (ps2_valid_i) begin
      pack_q <= pack_next;
      idx_q  <= idx_q + 2'd1;
    end
  end

  // FIFO storage; writes the completed word at the tail on a successful push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage is reset because word_data_o reads the head slot
      // directly and must show zero while empty after reset; at this depth
      // the array is a handful of flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (ps2_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= pack_next;
    end
  end

  // Read/write pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (ps2_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Saturating count of accepted words and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (ps2_reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok && (count_q != '1)) count_q <= count_q + CNT_ONE;
      if (push_req && !push_ok)       overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_word_packer.sv
// Directed bench for ps2_word_packer. Expected words are queued when the
// completing stimulus is driven and compared whenever a handshake occurs.
module tb_ps2_word_packer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b0;
  logic [7:0]       ps2_data_i = '0;
  logic             ps2_valid_i = 1'b0;
  logic             ps2_done = 1'b0;
  logic             ps2_reset = 1'b0;
  logic [31:0]      word_data_o;
  logic             word_valid_o;
  logic             word_ready_i = 1'b0;
  logic [CNT_W-1:0] word_count_o;
  logic             overflow_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  ps2_word_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ps2_data_i   (ps2_data_i),
    .ps2_valid_i  (ps2_valid_i),
    .ps2_done     (ps2_done),
    .ps2_reset    (ps2_reset),
    .word_data_o  (word_data_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_count_o (word_count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake seen at the falling edge pops one expected word.
  always @(negedge clk) begin
    if (rst && word_valid_o && word_ready_i) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_word: observed %h expected none", word_data_o);
      end
      if (exp_q.size() != 0) check("pop_data", word_data_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic done);
    ps2_data_i  = b;
    ps2_valid_i = 1'b1;
    ps2_done    = done;
    tick();
    ps2_valid_i = 1'b0;
    ps2_done    = 1'b0;
  endtask

  task automatic pulse_done();
    ps2_done = 1'b1;
    tick();
    ps2_done = 1'b0;
  endtask

  task automatic pulse_ps2_reset();
    ps2_reset = 1'b1;
    tick();
    ps2_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;

    // Reset state while rst is held low
    #2;
    check("rst_valid", 32'(word_valid_o), 32'd0);
    check("rst_data", word_data_o, 32'h0);
    check("rst_count", 32'(word_count_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Full word, one-cycle latency, popped immediately
    word_ready_i = 1'b1;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    check("partial_no_valid", 32'(word_valid_o), 32'd0);
    exp_q.push_back(32'h12345678);
    send_byte(8'h78, 1'b0);
    check("w1_valid", 32'(word_valid_o), 32'd1);
    check("w1_data", word_data_o, 32'h12345678);
    tick();
    check("w1_popped", 32'(word_valid_o), 32'd0);
    check("w1_count", 32'(word_count_o), 32'd1);

    // Partial word flushed by ps2_done; second done with idx 0 is a no-op
    exp_q.push_back(32'hABCD0000);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    pulse_done();
    check("flush_valid", 32'(word_valid_o), 32'd1);
    check("flush_data", word_data_o, 32'hABCD0000);
    tick();
    pulse_done();
    tick();
    check("idle_done_valid", 32'(word_valid_o), 32'd0);
    check("idle_done_count", 32'(word_count_o), 32'd2);

    // Last byte together with ps2_done: exactly one word
    exp_q.push_back(32'h01020304);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    check("cmb_valid", 32'(word_valid_o), 32'd1);
    check("cmb_data", word_data_o, 32'h01020304);
    tick();
    check("cmb_count", 32'(word_count_o), 32'd3);
    tick();
    check("cmb_no_extra", 32'(word_valid_o), 32'd0);
    check("cmb_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: DEPTH+1 words with the consumer blocked
    word_ready_i = 1'b0;
    pulse_ps2_reset();
    check("clr_count", 32'(word_count_o), 32'd0);
    for (int wi = 0; wi <= DEPTH; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        b = 8'(8'h10 * (wi + 1) + k);
        w = {w[23:0], b};
        if (k == 3 && wi < DEPTH) exp_q.push_back(w);
        send_byte(b, 1'b0);
      end
    end
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(word_count_o), DEPTH);
    check("ovf_head", word_data_o, 32'h10111213);

    // Stall with a full FIFO and ready high: no valid, no pops
    stall = 1'b1;
    word_ready_i = 1'b1;
    #1;
    check("stall_valid", 32'(word_valid_o), 32'd0);
    tick();
    tick();
    tick();
    check("stall_valid_hold", 32'(word_valid_o), 32'd0);
    check("stall_head_hold", word_data_o, 32'h10111213);
    check("stall_sb_size", 32'(exp_q.size()), DEPTH);

    // Release stall: back-to-back drain in order
    stall = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 32'(word_valid_o), 32'd1);
      tick();
    end
    check("drain_done_valid", 32'(word_valid_o), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // ps2_reset with two queued words and a partial word
    word_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i), 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("pre_clr_valid", 32'(word_valid_o), 32'd1);
    pulse_ps2_reset();
    check("clr_valid", 32'(word_valid_o), 32'd0);
    check("clr_data", word_data_o, 32'h0);
    check("clr_count2", 32'(word_count_o), 32'd0);
    check("clr_overflow", 32'(overflow_o), 32'd0);
    word_ready_i = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    check("dead_data", word_data_o, 32'hDEADBEEF);
    tick();
    check("dead_count", 32'(word_count_o), 32'd1);

    // Asynchronous rst mid-word with one word queued
    word_ready_i = 1'b0;
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b0);
    check("pre_rst_count", 32'(word_count_o), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(word_valid_o), 32'd0);
    check("arst_data", word_data_o, 32'h0);
    check("arst_count", 32'(word_count_o), 32'd0);
    check("arst_overflow", 32'(overflow_o), 32'd0);
    tick();
    rst = 1'b1;
    word_ready_i = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h0D, 1'b0);
    check("post_rst_data", word_data_o, 32'hCAFEF00D);
    tick();
    check("post_rst_count", 32'(word_count_o), 32'd1);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
